// File: rtl/decode_bcd_4to10_scan_if.sv
// decode_bcd_4to10_scan_if: digit handshake plus scanned display lines for the BCD scan decoder
interface decode_bcd_4to10_scan_if #(parameter int DIGITS = 4);
   logic [0:3]        in;
   logic              in_valid;
   logic              in_ready;
   logic [0:9]        out;
   logic [0:DIGITS-1] sel;
   logic              err;
   modport master (output in, in_valid, input in_ready, out, sel, err);
   modport slave (input in, in_valid, output in_ready, out, sel, err);
endinterface

// File: rtl/decode_bcd_4to10_scan.sv
// decode_bcd_4to10_scan: double-buffered BCD frame scanned onto active-low 10-line output; DECODE_LZB_EN enables leading-zero blanking
module decode_bcd_4to10_scan #(
   parameter int DIGITS = 4,
   parameter int DWELL  = 1000
) (
   input logic clk,
   input logic rst,
   decode_bcd_4to10_scan_if.slave bus
);
   localparam int CW = $clog2(DWELL);
   localparam int IW = $clog2(DIGITS);
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx, wptr;
   logic [3:0]        shadow [DIGITS];
   logic [3:0]        disp [DIGITS];
   logic              pending, err_r;
   logic [0:9]        out_r, dec;
   logic [0:DIGITS-1] sel_r, sel_v, mask;
   logic [3:0]        code;
   logic              accept, tick, frame, commit;
   assign bus.in_ready = ~pending & ~rst;
   assign bus.out      = out_r;
   assign bus.sel      = sel_r;
   assign bus.err      = err_r;
   // handshake and scan-event decode; in[0] carries weight 1
   always_comb begin
      code   = {bus.in[3], bus.in[2], bus.in[1], bus.in[0]};
      accept = bus.in_valid & bus.in_ready;
      tick   = cnt == CW'(DWELL - 1);
      frame  = tick & (idx == IW'(DIGITS - 1));
      commit = frame & pending;
   end
   // dwell counter and scanned position
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= frame ? '0 : idx + 1'b1;
      end
   end
   // shadow fill, frame-boundary commit and sticky invalid-code flag
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow  <= '{default: 4'd0};
         disp    <= '{default: 4'd15};
         wptr    <= '0;
         pending <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         if (accept) begin
            shadow[wptr] <= code;
            wptr         <= (wptr == IW'(DIGITS - 1)) ? '0 : wptr + 1'b1;
            if (wptr == IW'(DIGITS - 1)) pending <= 1'b1;
            if (code > 4'd9) err_r <= 1'b1;
         end
         if (commit) begin
            disp    <= shadow;
            pending <= 1'b0;
         end
      end
   end
`ifdef DECODE_LZB_EN
   logic [0:DIGITS-1] mask_nxt;
   logic              lz;
   // leading-zero mask of the frame about to be committed; last position always shown
   always_comb begin
      mask_nxt = '0;
      lz       = 1'b1;
      for (int p = 0; p < DIGITS - 1; p++) begin
         lz          = lz & (shadow[p] == 4'd0);
         mask_nxt[p] = lz;
      end
   end
   // mask follows the display buffer, updated only at commit
   always_ff @(posedge clk) begin
      if (rst) mask <= '0;
      else if (commit) mask <= mask_nxt;
   end
`else
   assign mask = '0;
`endif
   // 7442-style decode of the scanned position; codes above 9 and masked zeros stay dark
   always_comb begin
      dec   = '1;
      sel_v = '1;
      for (int n = 0; n < 10; n++) dec[n] = mask[idx] | (disp[idx] != 4'(n));
      sel_v[idx] = 1'b0;
   end
   // registered outputs, blanked on the first cycle of every dwell for ghost suppression
   always_ff @(posedge clk) begin
      if (rst | (cnt == '0)) begin
         out_r <= '1;
         sel_r <= '1;
      end else begin
         out_r <= dec;
         sel_r <= sel_v;
      end
   end
endmodule

// File: tb/tb_decode_bcd_4to10_scan.sv
// tb_decode_bcd_4to10_scan: randomized scoreboard bench for the BCD scan decoder (DIGITS=2, DWELL=4)
module tb_decode_bcd_4to10_scan;
   localparam int D = 2;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   decode_bcd_4to10_scan_if #(.DIGITS(D)) bus ();
   decode_bcd_4to10_scan #(.DIGITS(D), .DWELL(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_cmp = 0;
   int n_bad = 0;
   int t, wp, cur, vprob, maxcode;
   bit pend, merr;
   int sh [D];
   int dp [D];
   int q [$];
   logic [0:9]   eo;
   logic [0:D-1] es;
   logic         ee, er;
   task automatic model_reset();
      t = 0; wp = 0; pend = 0; merr = 0;
      for (int i = 0; i < D; i++) begin sh[i] = 0; dp[i] = 15; end
   endtask
   task automatic set_in(int v);
      cur = v;
      bus.in = {v[0], v[1], v[2], v[3]};
   endtask
   task automatic next_input();
      if (q.size() > 0) begin
         bus.in_valid = 1'b1;
         set_in(q.pop_front());
      end else begin
         bus.in_valid = ($urandom_range(99) < vprob);
         set_in($urandom_range(maxcode));
      end
   endtask
   // one clock: expected outputs come from the time position t and the committed frame
   task automatic cycle();
      int c, k;
      bit acc, lz;
      eo = '1; es = '1;
      c = t % W;
      k = (t / W) % D;
      if (!rst && c != 0) begin
         es[k] = 1'b0;
         lz = (k < D - 1);
         for (int p = 0; p <= k; p++) if (dp[p] != 0) lz = 0;
`ifndef DECODE_LZB_EN
         lz = 0;
`endif
         if (!lz && dp[k] <= 9) eo[dp[k]] = 1'b0;
      end
      acc = bus.in_valid && !pend && !rst;
      if (rst) model_reset();
      else begin
         if (pend && c == W - 1 && k == D - 1) begin
            for (int i = 0; i < D; i++) dp[i] = sh[i];
            pend = 0;
         end
         if (acc) begin
            sh[wp] = cur;
            if (cur > 9) merr = 1;
            wp++;
            if (wp == D) begin wp = 0; pend = 1; end
         end
         t++;
      end
      @(posedge clk);
      #1;
      ee = merr;
      er = !pend && !rst;
      if (acc || !bus.in_valid) next_input();
   endtask
   task automatic test_reset();
      rst = 1'b1; bus.in_valid = 1'b0; vprob = 0; maxcode = 9;
      for (int i = 0; i < 3 * D * W + 2; i++) begin
         if (i == 2) rst = 1'b0;
         cycle();
         n_cmp++;
         if ({bus.out, bus.sel, bus.err, bus.in_ready} !== {eo, es, ee, er}) begin
            n_bad++;
            $display("FAIL reset cyc %0d: got out=%b sel=%b err=%b rdy=%b want out=%b sel=%b err=%b rdy=%b", i, bus.out, bus.sel, bus.err, bus.in_ready, eo, es, ee, er);
         end
      end
   endtask
   task automatic test_back_to_back();
      vprob = 0; q = '{3, 7};
      if (!bus.in_valid) next_input();
      for (int i = 0; i < 4 * D * W; i++) begin
         cycle();
         n_cmp++;
         if ({bus.out, bus.sel, bus.err, bus.in_ready} !== {eo, es, ee, er}) begin
            n_bad++;
            $display("FAIL back_to_back cyc %0d: got out=%b sel=%b err=%b rdy=%b want out=%b sel=%b err=%b rdy=%b", i, bus.out, bus.sel, bus.err, bus.in_ready, eo, es, ee, er);
         end
      end
   endtask
   task automatic test_backpressure();
      vprob = 100; maxcode = 9; q = '{9};
      if (!bus.in_valid) next_input();
      for (int i = 0; i < 8 * D * W; i++) begin
         cycle();
         n_cmp++;
         if ({bus.out, bus.sel, bus.err, bus.in_ready} !== {eo, es, ee, er}) begin
            n_bad++;
            $display("FAIL backpressure cyc %0d: got out=%b sel=%b err=%b rdy=%b want out=%b sel=%b err=%b rdy=%b", i, bus.out, bus.sel, bus.err, bus.in_ready, eo, es, ee, er);
         end
      end
      vprob = 0;
   endtask
   task automatic test_invalid();
      vprob = 0; q = '{12, 5};
      if (!bus.in_valid) next_input();
      for (int i = 0; i < 12 * D * W; i++) begin
         if (i == 4 * D * W) begin vprob = 50; maxcode = 15; end
         cycle();
         n_cmp++;
         if ({bus.out, bus.sel, bus.err, bus.in_ready} !== {eo, es, ee, er}) begin
            n_bad++;
            $display("FAIL invalid cyc %0d: got out=%b sel=%b err=%b rdy=%b want out=%b sel=%b err=%b rdy=%b", i, bus.out, bus.sel, bus.err, bus.in_ready, eo, es, ee, er);
         end
      end
      vprob = 0; maxcode = 9;
   endtask
   task automatic test_reset_mid();
      for (int i = 0; i < 6 * D * W; i++) begin
         rst = (i == 0 || i == 2);
         if (i == 0) bus.in_valid = 1'b0;
         if (i == 1) begin q = '{8}; next_input(); end
         if (i == 3) begin q = '{5, 6}; next_input(); end
         cycle();
         n_cmp++;
         if ({bus.out, bus.sel, bus.err, bus.in_ready} !== {eo, es, ee, er}) begin
            n_bad++;
            $display("FAIL reset_mid cyc %0d: got out=%b sel=%b err=%b rdy=%b want out=%b sel=%b err=%b rdy=%b", i, bus.out, bus.sel, bus.err, bus.in_ready, eo, es, ee, er);
         end
      end
      rst = 1'b0;
   endtask
   task automatic test_lzb();
      for (int i = 0; i < 16 * D * W; i++) begin
         rst = (i == 0);
         if (i == 0) bus.in_valid = 1'b0;
         if (i == 1) begin q = '{0, 4}; next_input(); end
         if (i == 4 * D * W) begin vprob = 60; maxcode = 2; end
         cycle();
         n_cmp++;
         if ({bus.out, bus.sel, bus.err, bus.in_ready} !== {eo, es, ee, er}) begin
            n_bad++;
            $display("FAIL lzb cyc %0d: got out=%b sel=%b err=%b rdy=%b want out=%b sel=%b err=%b rdy=%b", i, bus.out, bus.sel, bus.err, bus.in_ready, eo, es, ee, er);
         end
      end
      rst = 1'b0;
   endtask
   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      vprob = 0;
      maxcode = 9;
      set_in(0);
      model_reset();
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_invalid();
      test_reset_mid();
      test_lzb();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
